tx_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one UART byte transmitter (TX) among NUM_REQ requesters.

---
 rtl/tx_rr_scheduler.sv | 113 +++++++++++
 tb/tb_tx_rr_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tx_rr_scheduler.sv
// tx_rr_scheduler: round-robin scheduler sharing one UART byte transmitter among NUM_REQ clients
module tx_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int PLOAD_CYC   = 400,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_pload,
  output logic                 tx_enable,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int MAX_PG = PLOAD_CYC > GAP_CYC ? PLOAD_CYC : GAP_CYC;
  localparam int MAX_C  = MAX_PG > TIMEOUT_CYC ? MAX_PG : TIMEOUT_CYC;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int PW     = $clog2(NUM_REQ);
  localparam logic [CW-1:0] P_LAST = CW'(PLOAD_CYC - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;
  state_t              state, state_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [PW-1:0]       ptr, ptr_nx, cur, cur_nx, pick;
  logic [NUM_REQ-1:0]  ack_nx, grant_nx;
  logic [7:0]          tx_data_nx;
  logic                terr_nx, found, done_rise;
  logic [2:0]          sync;
  function automatic int wrap(input int v);
    return v >= NUM_REQ ? v - NUM_REQ : v;
  endfunction
  assign done_rise = sync[1] & ~sync[2];
  assign tx_pload  = state == LOAD;
  assign tx_enable = state == LOAD || state == WAIT;
  assign busy      = state != IDLE;
  // first pending request at or after the pointer, wrapping around
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req[wrap(int'(ptr) + k)]) begin
        pick  = PW'(wrap(int'(ptr) + k));
        found = 1'b1;
      end
  end
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    ptr_nx     = ptr;
    cur_nx     = cur;
    ack_nx     = '0;
    grant_nx   = grant;
    tx_data_nx = tx_data;
    terr_nx    = timeout_err;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (found) begin
          state_nx   = LOAD;
          cur_nx     = pick;
          grant_nx   = NUM_REQ'(1) << pick;
          tx_data_nx = req_data[8*pick +: 8];
        end
      end
      LOAD: if (cnt == P_LAST) begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end
      // a completion edge wins over a timeout landing on the same cycle
      WAIT: if (done_rise || cnt == T_LAST) begin
        state_nx = GAP;
        cnt_nx   = '0;
        ack_nx   = grant;
        grant_nx = '0;
        ptr_nx   = PW'(wrap(int'(cur) + 1));
        terr_nx  = timeout_err | ~done_rise;
      end
      default: if (cnt == G_LAST) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      cur         <= '0;
      ack         <= '0;
      grant       <= '0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
      sync        <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ptr         <= ptr_nx;
      cur         <= cur_nx;
      ack         <= ack_nx;
      grant       <= grant_nx;
      tx_data     <= tx_data_nx;
      timeout_err <= terr_nx;
      sync        <= {sync[1:0], tx_done};
    end
endmodule

// File: tb/tb_tx_rr_scheduler.sv
// tb_tx_rr_scheduler: directed and randomized checks of tx_rr_scheduler against a queue-level model
module tb_tx_rr_scheduler;
  localparam int N  = 4;
  localparam int PL = 8;
  localparam int GP = 4;
  localparam int TO = 600;
  logic         CLOCK_50 = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [8*N-1:0] req_data;
  logic [N-1:0] ack, grant;
  logic [7:0]   tx_data;
  logic         tx_pload, tx_enable, tx_done, busy, timeout_err;
  logic [7:0]   cdata [N];
  logic [3:0]   add;
  int checks = 0, errors = 0, ptr = 0, g, n;
  tx_rr_scheduler #(.NUM_REQ(N), .PLOAD_CYC(PL), .GAP_CYC(GP), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .grant(grant), .tx_data(tx_data), .tx_pload(tx_pload), .tx_enable(tx_enable),
    .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err));
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic tick();
    @(negedge CLOCK_50);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic set_data(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
    cdata[i] = b;
  endtask
  // the next client to serve: first pending one at or after the pointer, wrapping
  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // serves client c from IDLE through GAP; dly<0 leaves tx_done low to force a timeout;
  // drop 1 releases req at ack, drop 2 right after grant
  task automatic service(input int c, input logic [7:0] d, input int dly, input int drop, input bit poke);
    int m;
    m = 0;
    while (grant == '0 && m < 20) begin tick(); m++; end
    check("grant", grant, 1 << c);
    check("tx_data", tx_data, d);
    if (drop == 2) req[c] = 1'b0;
    m = 0;
    while (tx_pload && m < PL + 5) begin tick(); m++; end
    check("pload_len", m, PL);
    check("wait_en_pload", {tx_enable, tx_pload}, 2'b10);
    if (poke) begin
      tick();
      tick();
      req_data[8*c +: 8] = ~d;
      tick();
      check("data_stable", tx_data, d);
    end
    if (dly >= 0) begin
      repeat (dly) tick();
      tx_done = 1'b1;
    end
    m = 0;
    while (ack == '0 && m < TO + 10) begin tick(); m++; end
    check(dly >= 0 ? "done_latency" : "timeout_latency", m, dly >= 0 ? 3 : TO);
    check("ack", ack, 1 << c);
    check("grant_clear", grant, 0);
    if (drop == 1) req[c] = 1'b0;
    tx_done = 1'b0;
    tick();
    check("ack_one_cycle", ack, 0);
    m = 2;
    while (busy && m < GP + 6) begin tick(); m++; end
    check("gap_len", m - 1, GP);
  endtask
  initial begin
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    for (int i = 0; i < N; i++) cdata[i] = 8'h00;
    repeat (3) begin
      tick();
      req = N'($urandom);
    end
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_outs", {busy, tx_pload, tx_enable, timeout_err}, 0);
    check("rst_tx_data", tx_data, 8'h00);
    req = '0;
    reset_n = 1'b1;
    req = 4'b0100;
    set_data(2, 8'hA5);
    service(2, 8'hA5, 500, 1, 0);
    ptr = 3;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ptr = 0;
    for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = rr_pick(req, ptr);
      service(g, cdata[g], $urandom_range(0, 4), 0, 0);
      ptr = (g + 1) % N;
    end
    req = '0;
    check("no_terr_yet", timeout_err, 0);
    req = 4'b0010;
    set_data(1, 8'h5A);
    service(1, 8'h5A, -1, 1, 0);
    ptr = 2;
    check("terr_set", timeout_err, 1);
    req = 4'b0001;
    set_data(0, 8'hC3);
    g = rr_pick(req, ptr);
    service(g, 8'hC3, 2, 1, 0);
    ptr = (g + 1) % N;
    check("terr_sticky", timeout_err, 1);
    req = 4'b0010;
    set_data(1, 8'h3C);
    g = rr_pick(req, ptr);
    service(g, 8'h3C, 2, 1, 1);
    ptr = (g + 1) % N;
    req = 4'b1000;
    set_data(3, 8'h77);
    n = 0;
    while (grant == '0 && n < 20) begin tick(); n++; end
    check("mid_grant", grant, 4'b1000);
    check("grant_latency", n, 1);
    repeat (PL + 3) tick();
    check("mid_wait", {tx_enable, tx_pload}, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_outs", {busy, tx_pload, tx_enable, timeout_err}, 0);
    check("mid_rst_ack", ack, 0);
    tick();
    check("mid_rst_no_ack", ack, 0);
    reset_n = 1'b1;
    ptr = 0;
    g = rr_pick(req, ptr);
    service(g, 8'h77, 1, 1, 0);
    ptr = (g + 1) % N;
    for (int it = 0; it < 16; it++) begin
      add = 4'($urandom);
      for (int i = 0; i < N; i++)
        if (add[i] && !req[i]) begin
          req[i] = 1'b1;
          set_data(i, 8'($urandom));
        end
      if (req == '0) begin
        req[it % N] = 1'b1;
        set_data(it % N, 8'($urandom));
      end
      g = rr_pick(req, ptr);
      service(g, cdata[g], $urandom_range(0, 6), $urandom_range(1, 2), 0);
      ptr = (g + 1) % N;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
